// File: rtl/riscv_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state
// encoding and the master identifiers used for grants.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/riscv_rr_arb2.sv
// Combinational two-way picker: round-robin on ties unless FIXED_PRIO,
// in which case master 0 always wins a tie.
module riscv_rr_arb2
  import riscv_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  always_comb begin
    grant_valid_o = |req_i;
    grant_id_o    = ARB_M0;
    unique case (req_i)
      2'b01:   grant_id_o = ARB_M0;
      2'b10:   grant_id_o = ARB_M1;
      // A tie goes to whichever master was not served last
      2'b11:   grant_id_o = FIXED_PRIO ? ARB_M0 : ~last_grant_i;
      default: grant_id_o = ARB_M0;
    endcase
  end

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Two-master data-memory arbiter (LSU = master 0, DMA/debug = master 1).
// Optional bus timeout enabled by defining RISCV_DMEM_ARB_TIMEOUT_EN.
module riscv_dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wd_i,
  output logic [31:0] m0_rd_o,
  output logic        m0_ready_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wd_i,
  output logic [31:0] m1_rd_o,
  output logic        m1_ready_o,
  output logic        m1_err_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("riscv_dmem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_t state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       grant_valid, grant_id;
  logic       timeout;
  logic       busy, sel_m1, done;
  logic [31:0] rd_mux;

  riscv_rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_pick (
    .req_i         ({m1_req_i, m0_req_i}),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

`ifdef RISCV_DMEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is held at zero while idle, so it reads zero on BUSY entry
  assign timeout = (state_q != IDLE) && !mem_ready_i &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE || mem_ready_i || timeout) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= ARB_M1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d      = (grant_id == ARB_M1) ? BUSY1 : BUSY0;
          last_grant_d = grant_id;
        end
      end
      // Always return to IDLE after a transfer: one dead cycle between grants
      BUSY0, BUSY1: begin
        if (mem_ready_i || timeout) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign sel_m1 = (state_q == BUSY1);
  assign done   = mem_ready_i || timeout;
  assign rd_mux = mem_ready_i ? mem_rd_i : 32'h0;

  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_be_o   = 4'h0;
    mem_addr_o = 32'h0;
    mem_wd_o   = 32'h0;
    m0_ready_o = 1'b0;
    m0_err_o   = 1'b0;
    m0_rd_o    = 32'h0;
    m1_ready_o = 1'b0;
    m1_err_o   = 1'b0;
    m1_rd_o    = 32'h0;
    if (busy) begin
      mem_req_o = 1'b1;
      if (sel_m1) begin
        mem_we_o   = m1_we_i;
        mem_be_o   = m1_be_i;
        mem_addr_o = m1_addr_i;
        mem_wd_o   = m1_wd_i;
        m1_ready_o = done;
        m1_err_o   = timeout;
        m1_rd_o    = rd_mux;
      end else begin
        mem_we_o   = m0_we_i;
        mem_be_o   = m0_be_i;
        mem_addr_o = m0_addr_i;
        mem_wd_o   = m0_wd_i;
        m0_ready_o = done;
        m0_err_o   = timeout;
        m0_rd_o    = rd_mux;
      end
    end
  end

endmodule
